// File: rtl/mem_responder_if.sv
// CPU memory bus: command, word address, store data and registered load data.
// The CPU side drives the request; the responder returns read_data.
interface mem_responder_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side bus responder: word RAM, LED register, switch port, sticky unmapped-access fault.
// LED/switch decoding is present only when MEM_RESPONDER_MMIO_EN is defined.
module mem_responder #(
    parameter int         RAM_AW   = 8,
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] SW_ADDR  = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    input  logic [7:0]        sw,
    output logic [7:0]        ledr,
    output logic              fault,
    output logic [8:0]        fault_addr
);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [1:0] SRC_ZERO = 2'd0;
    localparam logic [1:0] SRC_RAM  = 2'd1;
    localparam logic [1:0] SRC_MMIO = 2'd2;

    localparam int         RAM_WORDS = 2 ** RAM_AW;
    localparam logic [9:0] RAM_LIMIT = 10'(RAM_WORDS);

    logic              is_rd;
    logic              is_wr;
    logic              hit_ram;
    logic              hit_led;
    logic              hit_sw;
    logic              unmapped;
    logic [15:0]       mmio_val;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              ram_re;

    assign is_rd    = (bus.mem_cmd == CMD_READ);
    assign is_wr    = (bus.mem_cmd == CMD_WRITE);
    assign hit_ram  = ({1'b0, bus.mem_addr} < RAM_LIMIT);
    assign unmapped = (is_rd | is_wr) & ~hit_ram & ~hit_led & ~hit_sw;
    assign ram_idx  = bus.mem_addr[RAM_AW-1:0];

    // Gating with reset drops a write that is in flight while reset is asserted.
    assign ram_we = reset & is_wr & hit_ram;
    assign ram_re = reset & is_rd & hit_ram;

`ifdef MEM_RESPONDER_MMIO_EN
    logic [7:0] led_q, led_d;
    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;

    assign hit_led = (bus.mem_addr == LED_ADDR);
    assign hit_sw  = (bus.mem_addr == SW_ADDR);

    always_comb begin
        led_d   = led_q;
        sync1_d = sw;
        sync2_d = sync1_q;
        if (is_wr && hit_led) begin
            led_d = bus.write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= 8'h00;
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            led_q   <= led_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign mmio_val = hit_led ? {8'h00, led_q} : {8'h00, sync2_q};
    assign ledr     = led_q;
`else
    logic unused_mmio;

    assign hit_led     = 1'b0;
    assign hit_sw      = 1'b0;
    assign mmio_val    = 16'h0000;
    assign ledr        = 8'h00;
    assign unused_mmio = ^{sw, LED_ADDR, SW_ADDR};
`endif

    // Block RAM: no reset, registered read port enabled only on RAM reads so it
    // holds its word across idle cycles.
    logic [15:0] mem [RAM_WORDS];
    logic [15:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= bus.write_data;
        end
        if (ram_re) begin
            ram_rd_q <= mem[ram_idx];
        end
    end

    logic [1:0]  src_q, src_d;
    logic [15:0] mmio_rd_q, mmio_rd_d;
    logic        fault_q, fault_d;
    logic [8:0]  fault_addr_q, fault_addr_d;

    always_comb begin
        src_d        = src_q;
        mmio_rd_d    = mmio_rd_q;
        fault_d      = fault_q | unmapped;
        fault_addr_d = fault_addr_q;
        if (unmapped && !fault_q) begin
            fault_addr_d = bus.mem_addr;
        end
        if (is_rd) begin
            if (hit_ram) begin
                src_d = SRC_RAM;
            end else if (hit_led || hit_sw) begin
                src_d     = SRC_MMIO;
                mmio_rd_d = mmio_val;
            end else begin
                src_d = SRC_ZERO;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q        <= SRC_ZERO;
            mmio_rd_q    <= 16'h0000;
            fault_q      <= 1'b0;
            fault_addr_q <= 9'h000;
        end else begin
            src_q        <= src_d;
            mmio_rd_q    <= mmio_rd_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // The output select is reset, so read_data reads 0 during reset regardless of RAM.
    always_comb begin
        case (src_q)
            SRC_RAM:  bus.read_data = ram_rd_q;
            SRC_MMIO: bus.read_data = mmio_rd_q;
            default:  bus.read_data = 16'h0000;
        endcase
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, reset/switch sequences, randomized run against a model.
// Expectations follow MEM_RESPONDER_MMIO_EN the same way the design does.
module tb_mem_responder;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

`ifdef MEM_RESPONDER_MMIO_EN
    localparam bit         MMIO      = 1'b1;
    localparam logic [7:0] LED_AFTER = 8'h5A;
    localparam logic [8:0] FA1       = 9'h1F0;
`else
    localparam bit         MMIO      = 1'b0;
    localparam logic [7:0] LED_AFTER = 8'h00;
    localparam logic [8:0] FA1       = 9'h100;
`endif

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] rd;
        logic [7:0]  led;
        logic        f;
        logic [8:0]  fa;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] ledr;
    logic       fault;
    logic [8:0] fault_addr;

    mem_responder_if bus ();

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sw         (sw),
        .ledr       (ledr),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] m_mem [256];
    logic [15:0] m_rd;
    logic [7:0]  m_led;
    logic        m_fault;
    logic [8:0]  m_fa;
    logic [7:0]  sw_hist [$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] rd, input logic [7:0] led,
                             input logic f, input logic [8:0] fa);
        check({tag, ".read_data"}, bus.read_data, rd);
        check({tag, ".ledr"}, 16'(ledr), 16'(led));
        check({tag, ".fault"}, 16'(fault), 16'(f));
        check({tag, ".fault_addr"}, 16'(fault_addr), 16'(fa));
    endtask

    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;
        @(posedge clk);
        #1;
        $display("t=%0t cmd=%0d addr=%h wd=%h sw=%h -> rd=%h led=%h fault=%b fa=%h",
                 $time, c, a, d, sw, bus.read_data, ledr, fault, fault_addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.mem_cmd = N;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic model_reset();
        m_rd    = 16'h0000;
        m_led   = 8'h00;
        m_fault = 1'b0;
        m_fa    = 9'h000;
        sw_hist.delete();
        sw_hist.push_back(8'h00);
        sw_hist.push_back(8'h00);
    endtask

    // Called after an edge; the model state still holds pre-edge values.
    task automatic model_step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        logic [7:0] sync_val;
        bit is_ram, is_led, is_sw, bad;
        sync_val = sw_hist[sw_hist.size() - 2];
        sw_hist.push_back(sw);
        if (sw_hist.size() > 4) void'(sw_hist.pop_front());
        is_ram = (a < 9'd256);
        is_led = MMIO && (a == 9'h100);
        is_sw  = MMIO && (a == 9'h140);
        bad    = (c == R || c == W) && !is_ram && !is_led && !is_sw;
        if (c == R) begin
            if (is_ram)      m_rd = m_mem[a[7:0]];
            else if (is_led) m_rd = {8'h00, m_led};
            else if (is_sw)  m_rd = {8'h00, sync_val};
            else             m_rd = 16'h0000;
        end else if (c == W) begin
            if (is_ram)      m_mem[a[7:0]] = d;
            else if (is_led) m_led = d[7:0];
        end
        if (bad && !m_fault) begin
            m_fault = 1'b1;
            m_fa    = a;
        end
    endtask

    vec_t tab [$];

    task automatic add(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                       input logic [15:0] rd, input logic [7:0] led, input logic f,
                       input logic [8:0] fa);
        vec_t v;
        v.cmd = c; v.addr = a; v.wd = d; v.rd = rd; v.led = led; v.f = f; v.fa = fa;
        tab.push_back(v);
    endtask

    initial begin
        bus.mem_cmd    = N;
        bus.mem_addr   = 9'h000;
        bus.write_data = 16'h0000;
        sw             = 8'hC3;
        reset          = 1'b1;

        // Power-on reset asserted mid-cycle
        #2 reset = 1'b0;
        #1 check_all("por", 16'h0000, 8'h00, 1'b0, 9'h000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        step(W, 9'h005, 16'hABCD);
        step(R, 9'h005, 16'h0000);
        check("rst_then_read", bus.read_data, 16'hABCD);
        step(R, 9'h1F0, 16'h0000);
        step(W, 9'h100, 16'hFF5A);
        step(R, 9'h005, 16'h0000);
        check("pre_reset_fault", 16'(fault), 16'h0001);

        // Reset during an in-flight write: outputs clear at once and the write is lost
        @(negedge clk);
        bus.mem_cmd    = W;
        bus.mem_addr   = 9'h005;
        bus.write_data = 16'h5555;
        #2 reset = 1'b0;
        #1 check_all("mid_reset", 16'h0000, 8'h00, 1'b0, 9'h000);
        @(negedge clk);
        bus.mem_cmd = N;
        reset = 1'b1;
        step(R, 9'h005, 16'h0000);
        check("write_lost_in_reset", bus.read_data, 16'hABCD);

        // Directed table
        do_reset();
        add(W, 9'h000, 16'h1111, 16'h0000, 8'h00, 1'b0, 9'h000);
        add(W, 9'h0FF, 16'h2222, 16'h0000, 8'h00, 1'b0, 9'h000);
        add(R, 9'h000, 16'h0000, 16'h1111, 8'h00, 1'b0, 9'h000);
        add(R, 9'h0FF, 16'h0000, 16'h2222, 8'h00, 1'b0, 9'h000);
        add(N, 9'h000, 16'h0000, 16'h2222, 8'h00, 1'b0, 9'h000);
        add(X, 9'h0FF, 16'hFFFF, 16'h2222, 8'h00, 1'b0, 9'h000);
        add(R, 9'h0FF, 16'h0000, 16'h2222, 8'h00, 1'b0, 9'h000);
`ifdef MEM_RESPONDER_MMIO_EN
        add(W, 9'h100, 16'hFF5A, 16'h2222, 8'h5A, 1'b0, 9'h000);
        add(R, 9'h100, 16'h0000, 16'h005A, 8'h5A, 1'b0, 9'h000);
        add(W, 9'h140, 16'hFFFF, 16'h005A, 8'h5A, 1'b0, 9'h000);
        add(R, 9'h140, 16'h0000, 16'h00C3, 8'h5A, 1'b0, 9'h000);
        add(X, 9'h100, 16'h0000, 16'h00C3, 8'h5A, 1'b0, 9'h000);
`else
        add(W, 9'h100, 16'hFF5A, 16'h2222, 8'h00, 1'b1, 9'h100);
        add(R, 9'h140, 16'h0000, 16'h0000, 8'h00, 1'b1, 9'h100);
        add(X, 9'h100, 16'h00FF, 16'h0000, 8'h00, 1'b1, 9'h100);
`endif
        add(R, 9'h1F0, 16'h0000, 16'h0000, LED_AFTER, 1'b1, FA1);
        add(W, 9'h1A0, 16'h1234, 16'h0000, LED_AFTER, 1'b1, FA1);
        add(X, 9'h1A0, 16'h4321, 16'h0000, LED_AFTER, 1'b1, FA1);
        add(R, 9'h0FF, 16'h0000, 16'h2222, LED_AFTER, 1'b1, FA1);
        foreach (tab[i]) begin
            step(tab[i].cmd, tab[i].addr, tab[i].wd);
            check_all($sformatf("tab%0d", i), tab[i].rd, tab[i].led, tab[i].f, tab[i].fa);
        end

        // Reset clears the sticky fault
        do_reset();
        #1 check_all("fault_cleared", 16'h0000, 8'h00, 1'b0, 9'h000);

`ifdef MEM_RESPONDER_MMIO_EN
        // Switch change reaches a READ two edges later
        step(N, 9'h000, 16'h0000);
        sw = 8'h3C;
        step(R, 9'h140, 16'h0000);
        check("sw_edge0", bus.read_data, 16'h00C3);
        step(R, 9'h140, 16'h0000);
        check("sw_edge1", bus.read_data, 16'h00C3);
        step(R, 9'h140, 16'h0000);
        check("sw_edge2", bus.read_data, 16'h003C);
`endif

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 256; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            step(W, 9'(i), d);
            model_step(W, 9'(i), d);
            check_all("fill", m_rd, m_led, m_fault, m_fa);
        end
        for (int i = 0; i < 600; i++) begin
            logic [1:0]  c;
            logic [8:0]  a;
            logic [15:0] d;
            int          k;
            c = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            if (k <= 5)      a = 9'($urandom_range(0, 255));
            else if (k == 6) a = 9'h100;
            else if (k == 7) a = 9'h140;
            else             a = 9'h100 | 9'($urandom_range(0, 255));
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            step(c, a, d);
            model_step(c, a, d);
            check_all($sformatf("rnd%0d", i), m_rd, m_led, m_fault, m_fa);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
